// File: rtl/ov7670_stream_gen_pkg.sv
// Shared OV7670 definitions: FSM state encoding and default DVP frame timing.
// Used by the stream generator, the capture block and benches.
package ov7670_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBACK  = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFRONT = 3'd4
    } state_e;

    localparam int H_ACTIVE    = 1280;
    localparam int H_BLANK     = 288;
    localparam int VSYNC_LINES = 3;
    localparam int V_BACK      = 17;
    localparam int V_ACTIVE    = 480;
    localparam int V_FRONT     = 10;

endpackage

// File: rtl/ov7670_stream_gen_if.sv
// DVP stream generator bus: start level, framebuffer read port and sensor-style outputs.
// No backpressure: the framebuffer must answer every read one cycle later.
interface ov7670_stream_gen_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              fb_rd;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_data;
    logic              vsync;
    logic              href;
    logic [7:0]        d;
    logic              busy;
    logic              frame_done;

    modport master (
        input  start, fb_data,
        output fb_rd, fb_addr, vsync, href, d, busy, frame_done
    );

    modport slave (
        output start, fb_data,
        input  fb_rd, fb_addr, vsync, href, d, busy, frame_done
    );
endinterface

// File: rtl/ov7670_stream_gen_timing_cnt.sv
// Frame/line counters and FSM; raw rd/vs/busy/done strobes are combinational from state.
// No backpressure: once started a frame always runs to completion.
module ov7670_timing_cnt #(
    parameter int H_ACTIVE    = ov7670_pkg::H_ACTIVE,
    parameter int H_BLANK     = ov7670_pkg::H_BLANK,
    parameter int VSYNC_LINES = ov7670_pkg::VSYNC_LINES,
    parameter int V_BACK      = ov7670_pkg::V_BACK,
    parameter int V_ACTIVE    = ov7670_pkg::V_ACTIVE,
    parameter int V_FRONT     = ov7670_pkg::V_FRONT
) (
    input  logic pclk_24,
    input  logic rst,
    input  logic start_i,
    output logic rd_o,
    output logic vs_o,
    output logic busy_o,
    output logic done_o
);
    import ov7670_pkg::*;

    localparam int LINE  = H_ACTIVE + H_BLANK;
    localparam int H_W   = (LINE > 1) ? $clog2(LINE) : 1;
    localparam int V_M1  = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int V_M2  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int V_MAX = (V_M1 > V_M2) ? V_M1 : V_M2;
    localparam int V_W   = (V_MAX > 1) ? $clog2(V_MAX) : 1;
    localparam logic [H_W-1:0] H_LAST = H_W'(LINE - 1);
    localparam bit HAS_VBACK  = (V_BACK != 0);
    localparam bit HAS_VFRONT = (V_FRONT != 0);

    state_e         state_q, state_d;
    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;
    logic [V_W-1:0] len_m1;
    logic           line_end, last_line, frame_end;

    always_comb begin
        case (state_q)
            S_VSYNC:  len_m1 = V_W'(VSYNC_LINES - 1);
            S_VBACK:  len_m1 = V_W'(V_BACK - 1);
            S_ACTIVE: len_m1 = V_W'(V_ACTIVE - 1);
            S_VFRONT: len_m1 = V_W'(V_FRONT - 1);
            default:  len_m1 = '0;
        endcase
    end

    assign line_end  = (h_q == H_LAST);
    assign last_line = (v_q == len_m1);
    // With no front porch the frame ends on the last active cycle instead.
    assign frame_end = line_end && last_line &&
                       ((state_q == S_VFRONT) || ((state_q == S_ACTIVE) && !HAS_VFRONT));

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        if (state_q == S_IDLE) begin
            if (start_i) state_d = S_VSYNC;
        end else begin
            h_d = line_end ? '0 : h_q + 1'b1;
            if (line_end) begin
                if (last_line) begin
                    v_d = '0;
                    case (state_q)
                        S_VSYNC:  state_d = HAS_VBACK ? S_VBACK : S_ACTIVE;
                        S_VBACK:  state_d = S_ACTIVE;
                        S_ACTIVE: state_d = HAS_VFRONT ? S_VFRONT
                                          : (start_i ? S_VSYNC : S_IDLE);
                        S_VFRONT: state_d = start_i ? S_VSYNC : S_IDLE;
                        default:  state_d = S_IDLE;
                    endcase
                end else begin
                    v_d = v_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge pclk_24 or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    assign rd_o   = (state_q == S_ACTIVE) && (int'(h_q) < H_ACTIVE);
    assign vs_o   = (state_q == S_VSYNC);
    assign busy_o = (state_q != S_IDLE);
    assign done_o = frame_end;

endmodule

// File: rtl/ov7670_stream_gen.sv
// Framebuffer-to-DVP stream generator; 2-cycle read-to-href latency, all outputs pipe-aligned.
// No backpressure: reads are issued unconditionally during active line cycles.
module ov7670_stream_gen #(
    parameter int ADDR_W      = 8,
    parameter int H_ACTIVE    = ov7670_pkg::H_ACTIVE,
    parameter int H_BLANK     = ov7670_pkg::H_BLANK,
    parameter int VSYNC_LINES = ov7670_pkg::VSYNC_LINES,
    parameter int V_BACK      = ov7670_pkg::V_BACK,
    parameter int V_ACTIVE    = ov7670_pkg::V_ACTIVE,
    parameter int V_FRONT     = ov7670_pkg::V_FRONT
) (
    input  logic                       pclk_24,
    input  logic                       rst,
    ov7670_stream_gen_if.master        bus
);
    import ov7670_pkg::*;

    logic              rd, vs, run, done;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_p1_q, vs_p1_q, busy_p1_q, done_p1_q;
    logic              href_q, vsync_q, busy_q, done_q;
    logic [7:0]        d_q;

    ov7670_timing_cnt #(
        .H_ACTIVE    (H_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_ACTIVE    (V_ACTIVE),
        .V_FRONT     (V_FRONT)
    ) u_timing (
        .pclk_24 (pclk_24),
        .rst     (rst),
        .start_i (bus.start),
        .rd_o    (rd),
        .vs_o    (vs),
        .busy_o  (run),
        .done_o  (done)
    );

    // Address restarts every frame during vsync and wraps naturally at 2^ADDR_W.
    always_comb begin
        addr_d = addr_q;
        if (vs)      addr_d = '0;
        else if (rd) addr_d = addr_q + 1'b1;
    end

    always_ff @(posedge pclk_24 or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            rd_p1_q   <= 1'b0;
            vs_p1_q   <= 1'b0;
            busy_p1_q <= 1'b0;
            done_p1_q <= 1'b0;
            href_q    <= 1'b0;
            vsync_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            d_q       <= '0;
        end else begin
            addr_q    <= addr_d;
            rd_p1_q   <= rd;
            vs_p1_q   <= vs;
            busy_p1_q <= run;
            done_p1_q <= done;
            href_q    <= rd_p1_q;
            vsync_q   <= vs_p1_q;
            busy_q    <= busy_p1_q;
            done_q    <= done_p1_q;
            d_q       <= rd_p1_q ? bus.fb_data : 8'h00;
        end
    end

    assign bus.fb_rd      = rd;
    assign bus.fb_addr    = addr_q;
    assign bus.vsync      = vsync_q;
    assign bus.href       = href_q;
    assign bus.d          = d_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen with a 6-cycle line / 30-cycle frame configuration.
module tb_ov7670_stream_gen;

    logic pclk_24 = 1'b0;
    logic rst     = 1'b0;
    always #5 pclk_24 = ~pclk_24;

    ov7670_stream_gen_if #(.ADDR_W(3)) bus ();

    ov7670_stream_gen #(
        .ADDR_W(3), .H_ACTIVE(4), .H_BLANK(2), .VSYNC_LINES(1),
        .V_BACK(1), .V_ACTIVE(2), .V_FRONT(1)
    ) dut (
        .pclk_24 (pclk_24),
        .rst     (rst),
        .bus     (bus)
    );

    logic [7:0] ram [8];
    always @(posedge pclk_24)
        if (bus.fb_rd) bus.fb_data <= ram[bus.fb_addr];

    int vectors     = 0;
    int miscompares = 0;
    int viol        = 0;

    always @(negedge pclk_24)
        if (rst) begin
            if (bus.vsync && bus.href)        viol++;
            if (!bus.href && bus.d != 8'h00)  viol++;
        end

    logic [127:0] m_vs, m_href, m_rd, m_busy, m_done;
    logic [7:0]   dq [$];
    logic [2:0]   aq [$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rng(input int lo, input int hi);
        logic [127:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic rec(input int n, input int drop_at);
        m_vs = '0; m_href = '0; m_rd = '0; m_busy = '0; m_done = '0;
        dq.delete(); aq.delete();
        for (int k = 0; k < n; k++) begin
            @(negedge pclk_24);
            m_vs[k]   = bus.vsync;
            m_href[k] = bus.href;
            m_rd[k]   = bus.fb_rd;
            m_busy[k] = bus.busy;
            m_done[k] = bus.frame_done;
            if (bus.href)  dq.push_back(bus.d);
            if (bus.fb_rd) aq.push_back(bus.fb_addr);
            if (k == drop_at) bus.start = 1'b0;
        end
    endtask

    function automatic logic [63:0] pack8();
        logic [63:0] p = '0;
        for (int i = 0; i < 8 && i < dq.size(); i++) p[i*8 +: 8] = dq[i];
        return p;
    endfunction

    function automatic logic [63:0] exp8();
        logic [63:0] p = '0;
        for (int i = 0; i < 8; i++) p[i*8 +: 8] = 8'hA0 + 8'(i);
        return p;
    endfunction

    task automatic chk_frame(input string tag);
        chk({tag, "_vsync"}, m_vs,   rng(2, 7));
        chk({tag, "_href"},  m_href, rng(14, 17) | rng(20, 23));
        chk({tag, "_fb_rd"}, m_rd,   rng(12, 15) | rng(18, 21));
        chk({tag, "_busy"},  m_busy, rng(2, 31));
        chk({tag, "_done"},  m_done, rng(31, 31));
        chk({tag, "_d_seq"}, 128'(pack8()), 128'(exp8()));
    endtask

    initial begin
        int errs;
        for (int i = 0; i < 8; i++) ram[i] = 8'hA0 + 8'(i);
        bus.start   = 1'b0;
        bus.fb_data = 8'h00;

        // 1: reset state and idle with start low
        repeat (3) @(negedge pclk_24);
        chk("rst_outs", {bus.fb_rd, bus.fb_addr, bus.vsync, bus.href, bus.d, bus.busy, bus.frame_done}, '0);
        rst = 1'b1;
        rec(20, -1);
        chk("idle_outs", m_vs | m_href | m_rd | m_busy | m_done, '0);
        chk("idle_reads", dq.size() + aq.size(), 0);

        // 2: single frame, start dropped during vsync
        bus.start = 1'b1;
        rec(64, 3);
        chk_frame("one");
        chk("one_addr0", aq[0], 0);

        // 3: three back-to-back frames
        bus.start = 1'b1;
        rec(100, 85);
        chk("bb_vsync", m_vs, rng(2, 7) | rng(32, 37) | rng(62, 67));
        chk("bb_done",  m_done, rng(31, 31) | rng(61, 61) | rng(91, 91));
        chk("bb_busy",  m_busy, rng(2, 91));
        chk("bb_nrd",   aq.size(), 24);
        errs = 0;
        for (int k = 0; k < aq.size(); k++) if (aq[k] != 3'(k)) errs++;
        chk("bb_addr_seq", errs, 0);
        errs = 0;
        for (int k = 0; k < dq.size(); k++) if (dq[k] != 8'hA0 + 8'(k % 8)) errs++;
        chk("bb_d_seq", errs + (dq.size() == 24 ? 0 : 1000), 0);

        // 4: start dropped in the second active line
        bus.start = 1'b1;
        rec(64, 19);
        chk_frame("drop");

        // 5: reset in the middle of the second active line
        bus.start = 1'b1;
        rec(21, -1);
        chk("pre_rst_href", m_href, rng(14, 17) | rng(20, 20));
        chk("pre_rst_done", m_done, '0);
        rst = 1'b0;
        #1;
        chk("mid_rst_outs", {bus.fb_rd, bus.vsync, bus.href, bus.d, bus.busy, bus.frame_done}, '0);
        chk("mid_rst_addr", bus.fb_addr, 0);
        @(negedge pclk_24);
        rst = 1'b1;
        rec(64, 3);
        chk_frame("post");
        chk("post_addr0", aq[0], 0);

        // 6: protocol invariants over every sampled cycle
        chk("invariants", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
